pattern_tx: RTL
===============

# pattern_tx

Serial stimulus transmitter for the Mealy sequence detector. It accepts a parallel pattern word over a load handshake and shifts it out MSB-first on the single-bit line `x` that feeds the detector's input. Each bit is held for a programmable number of clocks, and each word is followed by an idle gap. It is the driving end of the detector's `x` interface: on-board it replaces the free-running bench toggle, so the detector can be exercised with deterministic bit sequences.

## Interface
- `WIDTH`, 8: pattern word length in bits; minimum 2.
- `BIT_CYCLES`, 1: clocks each bit is held on `x`; minimum 1.
- `GAP_CYCLES`, 2: clocks of `x=0` inserted after the last bit; 0 is legal.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high; sampled on the rising edge of `clk`.
- `load`  in  1  request to transmit `data`; sampled only in IDLE.
- `data`  in  WIDTH  pattern word; captured on the cycle `load` is accepted.
- `x`  out  1  serial bit stream to the detector's `x` input; registered.
- `busy`  out  1  high while a word or its gap is in progress; registered.
- `done`  out  1  single-cycle pulse at end of word plus gap; registered.

## Operation
- Reset values: `x=0`, `busy=0`, `done=0`, state IDLE, all counters 0, shift register 0.
- States:
  - IDLE: `x=0`, `busy=0`.
    - On `load=1`, capture `data` into the shift register, clear the bit counter and the hold counter, and go to SEND.
  - SEND: `x` = current MSB of the shift register; `busy=1`.
    - The hold counter counts 0..BIT_CYCLES-1.
    - At terminal hold count, shift left by one and increment the bit counter.
    - At the terminal hold of bit WIDTH-1, go to GAP, or go directly to IDLE with `done` if GAP_CYCLES=0.
  - GAP: `x=0`, `busy=1`.
    - The gap counter counts 0..GAP_CYCLES-1.
    - At terminal count, go to IDLE and assert `done` for that one transition.
- `load` while `busy=1` is ignored: no capture and no queueing; `data` changes are ignored.
- `load` in the cycle `done` is high is accepted, because the state is IDLE; back-to-back words are separated only by the gap.
- Counter widths: `$clog2` of (WIDTH, BIT_CYCLES, GAP_CYCLES), each at least 1 bit. Counters never exceed their terminal value and never wrap inside a word.
- `rst` mid-word: at the next edge all outputs and state return to their reset values. A partial word is abandoned and is not resumed; `done` is not pulsed.
- `rst` together with `load`: reset wins and nothing is captured.

## Timing
- `load` accepted at edge N:
  - `x` = `data[WIDTH-1]` from edge N+1.
  - Bit k occupies edges N+1+k·BIT_CYCLES through N+(k+1)·BIT_CYCLES.
- `busy` rises at edge N+1 and falls at edge N+WIDTH·BIT_CYCLES+GAP_CYCLES+1.
- `done` is high for exactly one cycle beginning at that same edge; `busy` is already 0 in the `done` cycle.
- Total occupancy per word: WIDTH·BIT_CYCLES+GAP_CYCLES clocks.
- Minimum `load`-to-`load` spacing: WIDTH·BIT_CYCLES+GAP_CYCLES+1 clocks.
- All outputs come straight from flops, with no combinational path from inputs to outputs.

## Configuration
- `PATTERN_TX_REPEAT_EN` defined:
  - At end of gap, if `load=0`, the last captured word is reloaded and SEND restarts immediately.
  - `done` still pulses once per word; `busy` stays 1 continuously.
  - If `load=1` at end of gap, the new `data` is captured instead.
  - Only `rst` returns the block to IDLE.
- `PATTERN_TX_REPEAT_EN` undefined: single-shot behaviour as described above; the reload register and mux are not built.

## Test plan
- Reset: hold `rst=1` for 3 cycles with `load=1`, `data=8'hFF` -> `x=0`, `busy=0`, `done=0` throughout, and nothing is transmitted after release.
- Basic word (WIDTH=8, BIT_CYCLES=2, GAP_CYCLES=3): load 8'hA5 at edge 0 -> `x` over cycles 1..16 = 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1; `x=0` on cycles 17..19; `done=1` on cycle 20 only; `busy=1` on cycles 1..19.
- Busy ignore: same config; load 8'hA5 at edge 0, then `load=1` with `data=8'h00` at edges 5..10 -> stream identical to the basic-word case.
- Back-to-back with GAP_CYCLES=0, BIT_CYCLES=1:
  - load 8'hC3 at edge 0 -> bits on cycles 1..8 = 1,1,0,0,0,0,1,1, and `done` on cycle 9.
  - load 8'h81 at edge 9 -> bits on cycles 10..17 = 1,0,0,0,0,0,0,1.
- Mid-word reset: load 8'hF0 at edge 0, `rst=1` at edge 4 -> `x=0`, `busy=0` from cycle 5; no `done`; a fresh load of 8'h0F then transmits correctly.
- With `PATTERN_TX_REPEAT_EN`: load 8'h96 once -> the word repeats every WIDTH·BIT_CYCLES+GAP_CYCLES clocks, with a `done` pulse each period and `busy` never dropping.

Source files
------------

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a loaded word out MSB-first on x, each bit held
// BIT_CYCLES clocks, then a GAP_CYCLES idle gap. Define PATTERN_TX_REPEAT_EN for auto-repeat.
module pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             fin;
  logic             hold_last;
  logic             bit_last;
  logic             gap_last;
  logic             word_end;
`ifdef PATTERN_TX_REPEAT_EN
  logic [WIDTH-1:0] last_word;
`endif

  assign hold_last = (hold_cnt == HOLD_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign word_end  = ((state == SEND) && hold_last && bit_last && (GAP_CYCLES == 0)) ||
                     ((state == GAP) && gap_last);

  // Outputs are registered from the current state, so they trail the state by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      fin      <= 1'b0;
      x        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef PATTERN_TX_REPEAT_EN
      last_word <= '0;
`endif
    end else begin
      x    <= (state == SEND) && shreg[WIDTH-1];
      busy <= (state != IDLE);
      done <= fin;
      fin  <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            shreg    <= data;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            state    <= SEND;
`ifdef PATTERN_TX_REPEAT_EN
            last_word <= data;
`endif
          end
        end
        SEND: begin
          if (hold_last) begin
            hold_cnt <= '0;
            shreg    <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_last) begin
              bit_cnt <= '0;
              if (GAP_CYCLES != 0) state <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (!gap_last) gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      // End of word (after the gap, or after the last bit when there is no gap)
      if (word_end) begin
        fin      <= 1'b1;
        gap_cnt  <= '0;
        bit_cnt  <= '0;
        hold_cnt <= '0;
`ifdef PATTERN_TX_REPEAT_EN
        state <= SEND;
        if (load) begin
          shreg     <= data;
          last_word <= data;
        end else begin
          shreg <= last_word;
        end
`else
        state <= IDLE;
`endif
      end
    end
  end

endmodule
